uart_rx_ctrl: RTL and testbench

//  Sequences the UART receiver datapath: detects the start bit, enables the rx block for one frame, and times the
//  mid-bit samples and stop-bit check. It captures the rx parallel output into a small FIFO drained by a valid/ready

---
 rtl/uart_rx_ctrl_if.sv | 11 +
 rtl/uart_rx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - host-side receive stream (FIFO head, valid/ready)
interface uart_rx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer with start detect, stop check and receive FIFO
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              line_in,
  output logic              rx_en,
  input  logic [DATA_W-1:0] rx_data,
  output logic              frame_err,
  output logic              overflow,
  input  logic              clr_flags,
  output logic              busy,
  uart_rx_ctrl_if.master    m_if
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  logic              sync1_q, sync1_d;
  logic              line_s_q, line_s_d;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic              armed_q, armed_d;
  logic              rx_en_q, rx_en_d;
  logic              overflow_q, overflow_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];

  logic push_req, frame_err_c, full, pop, push, drop;

  // Frame sequencer: start qualification, bit-centre timing, stop-bit check
  always_comb begin
    sync1_d     = line_in;
    line_s_d    = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    push_req    = 1'b0;
    frame_err_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable && armed_q && !line_s_q) state_d = S_START;
      end
      S_START: begin
        if (!enable) state_d = S_IDLE;
        else if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = line_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (!enable) state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == BIT_LAST) state_d = S_STOP;
        end
      end
      default: begin
        if (!enable) state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (line_s_q) push_req = 1'b1;
          else          frame_err_c = 1'b1;
        end
      end
    endcase
  end

  // Re-arm only after the line has been seen idle-high while waiting for a frame
  always_comb begin
    armed_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (state_d != S_IDLE) armed_d = 1'b0;
      else                   armed_d = armed_q | line_s_q;
    end
    rx_en_d = (state_d != S_IDLE);
  end

  // Receive FIFO bookkeeping; a pop frees the slot a same-cycle push needs
  always_comb begin
    full       = (count_q == DEPTH);
    pop        = (count_q != '0) && m_if.m_ready;
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    overflow_d = drop ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = rx_data;
  end

  // Control state registers with synchronous reset; synchronizer resets to idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      line_s_q   <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      armed_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      line_s_q   <= line_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      armed_q    <= armed_d;
      rx_en_q    <= rx_en_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output drive; head byte is masked to zero while the FIFO is empty
  always_comb begin
    m_if.m_valid = (count_q != '0);
    m_if.m_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    rx_en        = rx_en_q;
    frame_err    = frame_err_c;
    overflow     = overflow_q;
    busy         = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst, enable, line_in, clr_flags, m_ready;
  logic [7:0] rx_data;
  logic       rx_en, frame_err, overflow, busy;
  int         n_cmp = 0;
  int         n_err = 0;
  int         rx_en_cnt = 0;
  int         fe_cnt = 0;
  int         rx_base, fe_base;

  uart_rx_ctrl_if #(.DATA_W(8)) m_if ();
  assign m_if.m_ready = m_ready;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .line_in(line_in), .rx_en(rx_en),
    .rx_data(rx_data), .frame_err(frame_err), .overflow(overflow),
    .clr_flags(clr_flags), .busy(busy), .m_if(m_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_en === 1'b1) rx_en_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    rx_base = rx_en_cnt;
    fe_base = fe_cnt;
  endtask

  // One 10-bit frame plus 4 tail cycles at the stop level; entered and left at posedge+1
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop,
                            input int abort);
    logic [9:0] bits;
    int bi;
    bits = {stop, b, 1'b0};
    rx_data = b;
    for (int c = 0; c < 10 * CPB + 4; c++) begin
      bi = c / CPB;
      line_in = (bi > 9) ? stop : bits[bi];
      if (pop_at_stop) m_ready = (c == 154);
      if (abort == 1 && c == 66) enable = 1'b0;
      if (abort == 2) rst = (c == 66);
      if (abort != 0 && c == 67) begin
        chk("abort_busy", busy, 0);
        chk("abort_rx_en", rx_en, 0);
        chk("abort_m_valid", m_if.m_valid, (abort == 2) ? 0 : 1);
      end
      @(posedge clk); #1;
    end
    enable = 1'b1;
    if (pop_at_stop) m_ready = 1'b0;
  endtask

  task automatic drain(input logic [7:0] first, input int n);
    logic [7:0] e;
    m_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = first + 8'(i);
      chk("drain_valid", m_if.m_valid, 1);
      chk("drain_data", m_if.m_data, e);
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    chk("drain_empty", m_if.m_valid, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; line_in = 1'b1; clr_flags = 1'b0; m_ready = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_en", rx_en, 0);
    chk("rst_m_valid", m_if.m_valid, 0);
    chk("rst_m_data", m_if.m_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 1: good frame 0xA5 held in FIFO
    snap();
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    chk("t1_rx_en_cycles", rx_en_cnt - rx_base, 152);
    chk("t1_frame_err", fe_cnt - fe_base, 0);
    chk("t1_m_valid", m_if.m_valid, 1);
    chk("t1_m_data", m_if.m_data, 8'hA5);
    drain(8'hA5, 1);

    // 2: bad stop bit, then line held low must not start a frame
    snap();
    send_frame(8'hFF, 1'b0, 1'b0, 0);
    chk("t2_frame_err", fe_cnt - fe_base, 1);
    chk("t2_m_valid", m_if.m_valid, 0);
    snap();
    repeat (40) @(posedge clk);
    #1;
    chk("t2_low_no_start", rx_en_cnt - rx_base, 0);
    chk("t2_low_busy", busy, 0);
    line_in = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // 4: 4-clock glitch is a false start
    snap();
    line_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    line_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t4_rx_en_cycles", rx_en_cnt - rx_base, 8);
    chk("t4_frame_err", fe_cnt - fe_base, 0);
    chk("t4_m_valid", m_if.m_valid, 0);
    chk("t4_busy", busy, 0);

    // 3: five frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
    chk("t3_overflow_set", overflow, 1);
    drain(8'h01, 4);
    chk("t3_overflow_held", overflow, 1);
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    chk("t3_overflow_clr", overflow, 0);

    // 5: push and pop in the same cycle while full
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, 0);
    chk("t5_pre_overflow", overflow, 0);
    send_frame(8'h14, 1'b1, 1'b1, 0);
    chk("t5_overflow", overflow, 0);
    drain(8'h11, 4);

    // 6a: enable dropped in DATA bit 3 keeps FIFO contents
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    snap();
    send_frame(8'hFF, 1'b1, 1'b0, 1);
    chk("t6a_frame_err", fe_cnt - fe_base, 0);
    chk("t6a_m_data", m_if.m_data, 8'h5A);
    drain(8'h5A, 1);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    drain(8'h3C, 1);

    // 6b: reset in DATA bit 3 empties FIFO
    send_frame(8'h77, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 2);
    chk("t6b_m_valid", m_if.m_valid, 0);
    chk("t6b_overflow", overflow, 0);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    drain(8'h3C, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
